// File: rtl/generic_spi_peripheral.sv
// generic_spi_peripheral: SPI responder clocked by the forwarded spi_clk.
// Decodes one frame per cs_b low window (WnR bit, 4-bit address, data) and
// writes into or reads back from a parameterized register file.
// Optional error reporting (addr_err / err_count) is enabled by defining
// GENERIC_SPI_PERIPHERAL_ERR_EN; without it both outputs are tied to zero.
module generic_spi_peripheral #(
  parameter int                   NUM_REGS  = 16,
  parameter int                   REG_WIDTH = 32,
  parameter logic [15:0]          RO_MASK   = 16'h0000,
  parameter logic [REG_WIDTH-1:0] REG_RESET = '0
) (
  input  logic                            spi_clk,
  input  logic                            reset,
  input  logic                            cs_b,
  input  logic                            pico,
  output logic                            poci,
  output logic [NUM_REGS*REG_WIDTH-1:0]   regs_out,
  input  logic [NUM_REGS*REG_WIDTH-1:0]   regs_in,
  output logic [NUM_REGS-1:0]             reg_wr_pulse,
  output logic                            addr_err,
  output logic [7:0]                      err_count
);

  typedef enum logic [1:0] {IDLE, ADDR, WRITE_DATA, READ_DATA} state_t;

  state_t                 state_q;
  logic                   wnr_q;
  logic [3:0]             addr_q;
  logic [1:0]             addr_cnt_q;
  logic [7:0]             bit_cnt_q;
  logic [REG_WIDTH-1:0]   rx_q;
  // Bits of the read word still waiting behind the one currently on poci.
  logic [REG_WIDTH-2:0]   tx_q;
  logic                   poci_q;
  logic [NUM_REGS-1:0]    wr_pulse_q;
  logic [REG_WIDTH-1:0]   regs_q [NUM_REGS];

  logic [3:0]             rd_sel_d;
  logic [REG_WIDTH-1:0]   tx_load_d;
  logic                   addr_bad_d;
  logic                   commit_d;

  // Non-RO regs_in slices are never read; fold them into a sink.
  logic                   unused_regs_in;
  assign unused_regs_in = ^regs_in;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Read-word selection (address completed by the live pico bit) and commit qualification.
  always_comb begin
    rd_sel_d  = {addr_q[2:0], pico};
    tx_load_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel_d == 4'(i)) begin
        tx_load_d = RO_MASK[i] ? regs_in[i*REG_WIDTH +: REG_WIDTH] : regs_q[i];
      end
    end
    addr_bad_d = ({28'd0, addr_q} >= 32'(NUM_REGS));
    commit_d   = (state_q == WRITE_DATA) && cs_b && (bit_cnt_q != 8'd0) &&
                 !addr_bad_d && !RO_MASK[addr_q];
  end

  // Frame FSM with registered poci, write strobes and register file.
  always_ff @(posedge spi_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wnr_q      <= 1'b0;
      addr_q     <= 4'd0;
      addr_cnt_q <= 2'd0;
      bit_cnt_q  <= 8'd0;
      poci_q     <= 1'b0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET;
    end else begin
      wr_pulse_q <= '0;
      case (state_q)
        IDLE: begin
          poci_q <= 1'b0;
          if (!cs_b) begin
            wnr_q      <= pico;
            addr_cnt_q <= 2'd0;
            rx_q       <= '0;
            bit_cnt_q  <= 8'd0;
            state_q    <= ADDR;
          end
        end
        ADDR: begin
          if (cs_b) begin
            state_q <= IDLE;
          end else begin
            addr_q     <= rd_sel_d;
            addr_cnt_q <= addr_cnt_q + 2'd1;
            if (addr_cnt_q == 2'd3) begin
              if (wnr_q) begin
                state_q <= WRITE_DATA;
              end else begin
                state_q <= READ_DATA;
                tx_q    <= tx_load_d[REG_WIDTH-2:0];
                poci_q  <= tx_load_d[REG_WIDTH-1];
              end
            end
          end
        end
        WRITE_DATA: begin
          if (cs_b) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (commit_d && (addr_q == 4'(i))) begin
                regs_q[i]     <= rx_q;
                wr_pulse_q[i] <= 1'b1;
              end
            end
          end else begin
            rx_q      <= {rx_q[REG_WIDTH-2:0], pico};
            bit_cnt_q <= sat_inc8(bit_cnt_q);
          end
        end
        READ_DATA: begin
          if (cs_b) begin
            state_q <= IDLE;
            poci_q  <= 1'b0;
          end else begin
            poci_q <= tx_q[REG_WIDTH-2];
            tx_q   <= {tx_q[REG_WIDTH-3:0], 1'b0};
          end
        end
        default: begin
          state_q <= IDLE;
          poci_q  <= 1'b0;
        end
      endcase
    end
  end

  assign poci         = poci_q;
  assign reg_wr_pulse = wr_pulse_q;

  // Read-only registers expose their external source; the rest expose storage.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    if (RO_MASK[g]) begin : g_ro
      assign regs_out[g*REG_WIDTH +: REG_WIDTH] = regs_in[g*REG_WIDTH +: REG_WIDTH];
    end else begin : g_rw
      assign regs_out[g*REG_WIDTH +: REG_WIDTH] = regs_q[g];
    end
  end

`ifdef GENERIC_SPI_PERIPHERAL_ERR_EN
  logic       addr_err_q;
  logic [7:0] err_cnt_q;
  logic       err_d;

  // Error at frame end: short address phase, or an unimplemented address.
  assign err_d = cs_b && ((state_q == ADDR) ||
                          (((state_q == WRITE_DATA) || (state_q == READ_DATA)) && addr_bad_d));

  // One-cycle error strobe and saturating error counter.
  always_ff @(posedge spi_clk) begin
    if (reset) begin
      addr_err_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      addr_err_q <= err_d;
      if (err_d) err_cnt_q <= sat_inc8(err_cnt_q);
    end
  end

  assign addr_err  = addr_err_q;
  assign err_count = err_cnt_q;
`else
  assign addr_err  = 1'b0;
  assign err_count = 8'h00;
`endif

endmodule

// File: doc/generic_spi_peripheral.md
# generic_spi_peripheral

SPI responder for the on-chip side of the generic SPI link driven by the FPGA-side SPI controller. It decodes one frame per `cs_b` low window: a WnR bit, a 4-bit register address, then data. It writes into, or reads back from, a parameterized register file that drives the chip's configuration nets. The block sits on the chip digital core, clocked directly by the forwarded `spi_clk`.

## Interface
- `NUM_REGS`, 16: number of implemented registers, 1..16.
- `REG_WIDTH`, 32: register width in bits, 8..64.
- `RO_MASK`, 16'h0000: bit i set makes register i read-only; it reads `regs_in` slice i and ignores writes.
- `REG_RESET`, '0: reset value of every writable register.

Ports:
- `spi_clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cs_b`  in  1  frame select, active low.
- `pico`  in  1  serial data from controller, MSB first.
- `poci`  out  1  serial read data to controller, registered.
- `regs_out`  out  NUM_REGS*REG_WIDTH  register file contents; register i occupies bits [i*REG_WIDTH +: REG_WIDTH].
- `regs_in`  in  NUM_REGS*REG_WIDTH  read-only sources; same slicing; only read where `RO_MASK` is set.
- `reg_wr_pulse`  out  NUM_REGS  one-cycle strobe, bit i set the cycle after register i is committed.
- `addr_err`  out  1  one-cycle error strobe (see Configuration).
- `err_count`  out  8  saturating error counter (see Configuration).

## Operation
- States: IDLE, ADDR, WRITE_DATA, READ_DATA.
- **IDLE.** At an edge with `cs_b`=0:
  - capture `wnr` from `pico`;
  - clear `addr_cnt`, the data shift register and `bit_cnt`;
  - go to ADDR.
- **ADDR.** At each edge with `cs_b`=0, shift `pico` into `addr[3:0]` at the LSB, MSB first, and increment `addr_cnt`. On the 4th bit:
  - if `wnr`=1, go to WRITE_DATA;
  - if `wnr`=0, go to READ_DATA. At that same edge, load the tx shift register with the selected register value and drive `poci` with its MSB.
  - The selected value is: register `{addr[2:0],pico}`; `regs_in` slice if RO; 0 if the address is >= `NUM_REGS`.
- **WRITE_DATA.** At each edge with `cs_b`=0:
  - shift `pico` into the rx shift register at the LSB;
  - `bit_cnt` increments and saturates at 255.
- **READ_DATA.** At each edge with `cs_b`=0:
  - shift the tx register left, filling zeros;
  - `poci` takes the next bit. After REG_WIDTH bits, `poci`=0.
- **Frame end (`cs_b`=1 sampled in any non-IDLE state).** Go to IDLE at that edge. In WRITE_DATA with `bit_cnt`>=1, commit at that same edge:
  - the target register gets the low REG_WIDTH bits of the rx shift register;
  - fewer than REG_WIDTH bits leave the value zero-extended; more than REG_WIDTH keeps the last REG_WIDTH bits.
- Commit suppressed when any of these holds:
  - the address is >= `NUM_REGS`;
  - the register is RO;
  - `bit_cnt`=0.
- `cs_b` high in IDLE: no action. A single high cycle between frames is sufficient; a new frame may start on the very next edge.

## Timing
- Reset values: `poci`=0, `reg_wr_pulse`=0, `addr_err`=0, `err_count`=0, every writable register = `REG_RESET`, state IDLE.
- Reset asserted mid-frame aborts the frame with no commit. After reset releases, a frame starts only at an edge where `cs_b`=0 and the state is IDLE.
- Read latency:
  - the first data bit is valid in the cycle immediately after the edge sampling the last address bit;
  - one bit per cycle thereafter.
- Write latency: `regs_out` updates at the cs_b-high edge. `reg_wr_pulse` bit is high during the following cycle only.
- `poci`=0 whenever the state is not READ_DATA.
- Frame cost: 1 (WnR) + 4 (address) + N data cycles, plus 1 cs_b-high cycle.

## Configuration
- `GENERIC_SPI_PERIPHERAL_ERR_EN` defined: `addr_err` pulses for one cycle, the cycle after the frame-end edge, for either of:
  - a frame with address >= `NUM_REGS`;
  - a frame ending in ADDR before all 4 address bits have been sampled (short frame).
- With the macro defined, `err_count` increments on each `addr_err` pulse and saturates at 255.
- `GENERIC_SPI_PERIPHERAL_ERR_EN` undefined: `addr_err`=0 and `err_count`=0 permanently. No error logic is synthesized; the ports remain.

## Test plan
- Reset, then write frame WnR=1, addr=4'h3, 32 bits 32'hDEADBEEF, `cs_b` high -> `regs_out[3]`=32'hDEADBEEF at the cs_b-high edge; `reg_wr_pulse`=16'h0008 for exactly one cycle.
- Read frame WnR=0, addr=4'h3 -> `poci` shifts out 32'hDEADBEEF MSB first, starting the cycle after the last address bit. The 33rd cycle gives `poci`=0.
- Write 8 bits 8'hA5 to addr 4'h1 -> `regs_out[1]`=32'h000000A5. A 40-bit write of 40'h12_3456789A gives 32'h3456789A.
- Back-to-back frames with one cs_b-high cycle: write 0x1 to reg 0, then immediately read reg 0 -> the read returns 32'h00000001 with no lost bit.
- With `RO_MASK`=16'h0004 and `regs_in` slice 2 = 32'hCAFEF00D: a write to reg 2 is ignored (no `reg_wr_pulse`), and a read of reg 2 returns 32'hCAFEF00D.
- With `NUM_REGS`=8 and the macro defined:
  - a write to addr 4'hA leaves all registers unchanged, `addr_err` pulses once and `err_count`=1;
  - a frame with `cs_b` high after 2 address bits gives `err_count`=2;
  - reset asserted mid-write leaves registers at `REG_RESET`.
